// File: rtl/score_neighbor_addr_gen_pkg.sv
// score_neighbor_addr_gen_pkg: shared address-kind encodings, FSM state type and width helpers
// for the score-matrix neighbour address generator.
package score_neighbor_addr_gen_pkg;

    localparam logic [1:0] SIG_DIAG  = 2'b00;
    localparam logic [1:0] SIG_LEFT  = 2'b01;
    localparam logic [1:0] SIG_UP    = 2'b10;
    localparam logic [1:0] SIG_WRITE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIAG,
        S_LEFT,
        S_UP,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic int iw_f(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int jw_f(input int m);
        return $clog2(m + 1);
    endfunction

    function automatic int aw_f(input int n, input int m);
        return $clog2((n + 1) * (m + 1));
    endfunction

    // Address kind issued while in a given state; bit 1 selects row+1, bit 0 selects col+1.
    function automatic logic [1:0] sig_of(input state_t s);
        return (s == S_LEFT)  ? SIG_LEFT  :
               (s == S_UP)    ? SIG_UP    :
               (s == S_WRITE) ? SIG_WRITE : SIG_DIAG;
    endfunction

endpackage

// File: rtl/score_addr_calc.sv
// score_addr_calc: combinational (row, col) -> linear score-memory address, col + (M+1)*row.
// Ports: row [RW], col [CW] in; addr [AW] out (result taken modulo 2^AW).
module score_addr_calc #(
    parameter int M  = 128,
    parameter int RW = 9,
    parameter int CW = 9,
    parameter int AW = 15
) (
    input  logic [RW-1:0] row,
    input  logic [CW-1:0] col,
    output logic [AW-1:0] addr
);

    localparam int unsigned MP1 = M + 1;

    // Computed in 32 bits so legal indices never truncate before the final AW slice.
    assign addr = AW'(32'(col) + MP1 * 32'(row));

endmodule

// File: rtl/score_neighbor_addr_gen.sv
// score_neighbor_addr_gen: issues diagonal, left, up and write addresses of one score cell.
// Ports: clk, rst (async active-high); start, i, j request a cell; addr/signal/addr_valid with
// addr_ready handshake; busy while the sequence runs; done pulses once after the write address.
// Optional macro SCORE_ADDR_BOUNDS_CHECK_EN adds output err and rejects i>=N or j>=M.
module score_neighbor_addr_gen
    import score_neighbor_addr_gen_pkg::*;
#(
    parameter int N = 128,
    parameter int M = 128,
    localparam int IW = iw_f(N),
    localparam int JW = jw_f(M),
    localparam int AW = aw_f(N, M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [IW-1:0] i,
    input  logic [JW-1:0] j,
    output logic [AW-1:0] addr,
    output logic [1:0]    signal,
    output logic          addr_valid,
    input  logic          addr_ready,
    output logic          busy,
    output logic          done
`ifdef SCORE_ADDR_BOUNDS_CHECK_EN
    ,
    output logic          err
`endif
);

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic [AW-1:0] addr_q, addr_d, calc_addr;
    logic [1:0]    sig_q, sig_d, sig_n;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          accept, bad;
    logic [IW:0]   row;
    logic [JW:0]   col;

    assign accept = valid_q & addr_ready;

`ifdef SCORE_ADDR_BOUNDS_CHECK_EN
    assign bad = (i >= IW'(N)) || (j >= JW'(M));
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && bad) begin
                    err_d = 1'b1;
                end else if (start) begin
                    state_d = S_DIAG;
                    i_d     = i;
                    j_d     = j;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_DIAG:  state_d = accept ? S_LEFT : S_DIAG;
            S_LEFT:  state_d = accept ? S_UP : S_LEFT;
            S_UP:    state_d = accept ? S_WRITE : S_UP;
            S_WRITE: begin
                if (accept) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address for the state being entered; i_d/j_d already equal the inputs on the capture cycle.
    assign sig_n = sig_of(state_d);
    assign row   = (IW+1)'(i_d) + (IW+1)'(sig_n[1]);
    assign col   = (JW+1)'(j_d) + (JW+1)'(sig_n[0]);

    score_addr_calc #(
        .M (M),
        .RW(IW + 1),
        .CW(JW + 1),
        .AW(AW)
    ) u_calc (
        .row (row),
        .col (col),
        .addr(calc_addr)
    );

    // addr/signal only move when a new address is issued; otherwise they hold.
    assign addr_d = valid_d ? calc_addr : addr_q;
    assign sig_d  = valid_d ? sig_n : sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            addr_q  <= '0;
            sig_q   <= SIG_DIAG;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            addr_q  <= addr_d;
            sig_q   <= sig_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign addr       = addr_q;
    assign signal     = sig_q;
    assign addr_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef SCORE_ADDR_BOUNDS_CHECK_EN
    assign err        = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_score_neighbor_addr_gen.sv
// tb_score_neighbor_addr_gen: randomized check of score_neighbor_addr_gen against a formula model.
module tb_score_neighbor_addr_gen;

    localparam int NA = 4, MA = 3, IWA = 3, JWA = 2, AWA = 5;
    localparam int NB = 128, MB = 128, IWB = 8, JWB = 8, AWB = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           a_start, a_ready, a_valid, a_busy, a_done, a_err;
    logic [IWA-1:0] a_i;
    logic [JWA-1:0] a_j;
    logic [AWA-1:0] a_addr;
    logic [1:0]     a_sig;

    logic           b_start, b_ready, b_valid, b_busy, b_done, b_err;
    logic [IWB-1:0] b_i;
    logic [JWB-1:0] b_j;
    logic [AWB-1:0] b_addr;
    logic [1:0]     b_sig;

    int vecs = 0;
    int errs = 0;

    score_neighbor_addr_gen #(.N(NA), .M(MA)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .i(a_i), .j(a_j),
        .addr(a_addr), .signal(a_sig), .addr_valid(a_valid), .addr_ready(a_ready),
        .busy(a_busy), .done(a_done)
`ifdef SCORE_ADDR_BOUNDS_CHECK_EN
        , .err(a_err)
`endif
    );

    score_neighbor_addr_gen #(.N(NB), .M(MB)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .i(b_i), .j(b_j),
        .addr(b_addr), .signal(b_sig), .addr_valid(b_valid), .addr_ready(b_ready),
        .busy(b_busy), .done(b_done)
`ifdef SCORE_ADDR_BOUNDS_CHECK_EN
        , .err(b_err)
`endif
    );

`ifndef SCORE_ADDR_BOUNDS_CHECK_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // k: 0 diagonal, 1 left, 2 up, 3 write; row/col offsets follow the neighbour geometry.
    function automatic longint model_addr(input int m, input int aw, input int ii, input int jj, input int k);
        longint row = ii + ((k >= 2) ? 1 : 0);
        longint col = jj + ((k == 1 || k == 3) ? 1 : 0);
        return (col + (m + 1) * row) % (64'd1 << aw);
    endfunction

    // Runs one cell on dut_a starting at a negedge with the DUT idle; ends at a negedge, idle.
    task automatic txn_a(input int ii, input int jj, input bit stall, input int hold_at,
                         input bit noise, input bit done_start);
        int k = 0, cyc = 0, held = 0;
        a_start = 1'b1;
        a_i = ii[IWA-1:0];
        a_j = jj[JWA-1:0];
        a_ready = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("busy_run", a_busy, 1);
        while (k < 4 && cyc < 60) begin
            check("valid", a_valid, 1);
            check("addr", a_addr, model_addr(MA, AWA, ii, jj, k));
            check("signal", a_sig, k);
            check("done_low", a_done, 0);
            if (k == hold_at && held < 3) begin
                a_ready = 1'b0;
                held++;
            end else begin
                a_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (noise) begin
                a_start = 1'($urandom_range(0, 1));
                a_i = IWA'($urandom);
                a_j = JWA'($urandom);
            end
            if (a_ready) k++;
            cyc++;
            @(negedge clk);
        end
        check("txn_complete", k, 4);
        a_ready = 1'b1;
        a_start = done_start;
        a_i = IWA'($urandom);
        a_j = JWA'($urandom);
        check("done_pulse", a_done, 1);
        check("busy_done", a_busy, 0);
        check("valid_done", a_valid, 0);
        check("addr_hold", a_addr, model_addr(MA, AWA, ii, jj, 3));
        @(negedge clk);
        a_start = 1'b0;
        check("done_once", a_done, 0);
        check("valid_idle", a_valid, 0);
        check("busy_idle", a_busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        a_start = 0; a_i = 0; a_j = 0; a_ready = 1;
        b_start = 0; b_i = 0; b_j = 0; b_ready = 1;
        repeat (2) @(negedge clk);
        check("rst_addr", a_addr, 0);
        check("rst_sig", a_sig, 0);
        check("rst_valid", a_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_err", a_err, 0);
        rst = 1'b0;
        @(negedge clk);

        txn_a(1, 2, 0, -1, 0, 0);
        txn_a(1, 2, 0, 1, 0, 0);
        txn_a(1, 2, 0, -1, 1, 1);

        // Abort in the UP state: outputs must clear without waiting for a clock edge.
        a_start = 1'b1; a_i = 1; a_j = 2;
        repeat (3) begin
            @(negedge clk);
            a_start = 1'b0;
        end
        check("pre_abort_sig", a_sig, 2);
        rst = 1'b1;
        #1;
        check("abort_addr", a_addr, 0);
        check("abort_sig", a_sig, 0);
        check("abort_valid", a_valid, 0);
        check("abort_busy", a_busy, 0);
        check("abort_done", a_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_done", a_done, 0);
        check("post_abort_valid", a_valid, 0);
        txn_a(0, 0, 0, -1, 0, 0);

        // Large matrix: write address must not truncate.
        b_start = 1'b1; b_i = 127; b_j = 127;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b_start = 1'b0;
            check("b_valid", b_valid, 1);
            check("b_addr", b_addr, model_addr(MB, AWB, 127, 127, k));
            check("b_signal", b_sig, k);
        end
        check("b_write_16640", b_addr, 16640);
        @(negedge clk);
        check("b_done", b_done, 1);
        check("b_busy", b_busy, 0);

`ifdef SCORE_ADDR_BOUNDS_CHECK_EN
        a_start = 1'b1; a_i = 1; a_j = 3;
        @(negedge clk);
        a_start = 1'b0;
        check("err_pulse", a_err, 1);
        check("err_valid", a_valid, 0);
        check("err_busy", a_busy, 0);
        @(negedge clk);
        check("err_once", a_err, 0);
        check("err_valid2", a_valid, 0);
        check("err_busy2", a_busy, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            int ii, jj;
`ifdef SCORE_ADDR_BOUNDS_CHECK_EN
            ii = $urandom_range(0, NA - 1);
            jj = $urandom_range(0, MA - 1);
`else
            ii = $urandom_range(0, (1 << IWA) - 1);
            jj = $urandom_range(0, (1 << JWA) - 1);
`endif
            txn_a(ii, jj, 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/score_neighbor_addr_gen.md
SCORE_NEIGHBOR_ADDR_GEN -- requirements
Module: score_neighbor_addr_gen

Interface
REQ-001 Parameter N, default 128: length of sequence on rows; score matrix has N+1 rows.
REQ-002 Parameter M, default 128: length of sequence on columns; score matrix has M+1 columns.
REQ-003 Derived widths: IW = $clog2(N+1), JW = $clog2(M+1), AW = $clog2((N+1)*(M+1)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request to generate the addresses of one cell; sampled when idle.
REQ-007 i  input  IW  row index of the diagonal neighbour; captured with start.
REQ-008 j  input  JW  column index of the diagonal neighbour; captured with start.
REQ-009 addr  output  AW  score-memory address being issued.
REQ-010 signal  output  2  address kind: 00 diagonal, 01 left, 10 up, 11 write (target cell).
REQ-011 addr_valid  output  1  addr/signal valid this cycle.
REQ-012 addr_ready  input  1  consumer accepts addr when addr_valid and addr_ready are both high.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 done  output  1  one-cycle pulse after the write address is accepted.

Function
REQ-015 Address formula: addr = col + (M+1)*row, evaluated at full AW width, no truncation for legal indices.
REQ-016 Diagonal = (row i, col j); left = (row i, col j+1); up = (row i+1, col j); write = (row i+1, col j+1).
REQ-017 FSM states: IDLE, DIAG, LEFT, UP, WRITE, DONE.
REQ-018 IDLE: start=1 captures i,j, asserts busy, moves to DIAG next cycle; start=0 stays IDLE.
REQ-019 DIAG/LEFT/UP/WRITE: addr_valid=1 with matching addr and signal; advance to next state only on the cycle addr_valid & addr_ready; otherwise hold addr and signal stable.
REQ-020 Order fixed: DIAG -> LEFT -> UP -> WRITE -> DONE; minimum 4 cycles from first addr_valid to last acceptance.
REQ-021 DONE: done=1, busy=0, addr_valid=0 for exactly one cycle, then IDLE.
REQ-022 start while not in IDLE is ignored; captured i,j unchanged.
REQ-023 start during DONE is ignored; accepted no earlier than the following IDLE cycle.
REQ-024 Latency: start at cycle t with addr_ready held high -> diagonal at t+1, write accepted at t+4, done at t+5.
REQ-025 addr_valid=0 in IDLE and DONE; addr and signal hold last value when addr_valid=0.

Reset
REQ-026 On rst: state IDLE, addr=0, signal=00, addr_valid=0, busy=0, done=0, captured i,j=0.
REQ-027 rst asserted mid-sequence aborts immediately; no done pulse; first cycle after release is IDLE.

Configuration
REQ-028 Macro SCORE_ADDR_BOUNDS_CHECK_EN compiled in: add output err (1 bit, reset 0); start with i>=N or j>=M pulses err for one cycle, issues no address, busy stays 0, stays IDLE.
REQ-029 Macro absent: no err port; indices unchecked; out-of-range addresses are computed modulo 2^AW.

Structure
REQ-030 Shared package holds signal encodings (SIG_DIAG=00, SIG_LEFT=01, SIG_UP=10, SIG_WRITE=11), FSM state typedef, and width-derivation functions.
REQ-031 One sub-module score_addr_calc: combinational (row, col) -> address per REQ-015, instantiated once and muxed by state.

Verification
REQ-032 N=4, M=3, i=1, j=2, addr_ready=1: addresses 6/00, 7/01, 10/10, 11/11 on consecutive cycles, done at cycle t+5.
REQ-033 Same stimulus, addr_ready low 3 cycles during LEFT: addr=7, signal=01 held stable all 3 cycles, then sequence completes unchanged.
REQ-034 N=M=128, i=127, j=127: write address = 128+129*128 = 16640, no truncation at AW=15.
REQ-035 Reset asserted at UP state: all outputs to reset values asynchronously, no done; new start i=0,j=0 yields 0,1,129,130.
REQ-036 start pulsed while busy with different i,j: ignored, original addresses produced.
REQ-037 With SCORE_ADDR_BOUNDS_CHECK_EN, N=4, M=3, start with j=3: err one-cycle pulse, addr_valid never asserted, busy stays 0.
